// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared branch prediction types for fetch predictor and execute checker
package branch_pkg;

    typedef enum logic {
        TRACK   = 1'b0,
        RECOVER = 1'b1
    } boc_state_e;

    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        PRED_STRONG_NT = 2'b00,
        PRED_WEAK_NT   = 2'b01,
        PRED_WEAK_T    = 2'b10,
        PRED_STRONG_T  = 2'b11
    } pred_state_e;

endpackage

// File: rtl/branch_outcome_checker_if.sv
// rtl/branch_outcome_checker_if.sv - prediction/resolution/redirect signal bundle
interface branch_outcome_checker_if #(
    parameter int PC_W = 32
) ();

    logic            pred_valid;
    logic            pred_taken;
    logic [PC_W-1:0] pred_pc;
    logic [PC_W-1:0] pred_target;
    logic            pred_ready;
    logic            res_valid;
    logic            res_taken;
    logic [PC_W-1:0] res_target;
    logic            flush;
    logic [PC_W-1:0] redirect_pc;
    logic            upd_valid;
    logic            upd_taken;
    logic            err_underflow;
    logic            err_overflow;

    modport master (
        output pred_valid, pred_taken, pred_pc, pred_target,
        output res_valid, res_taken, res_target,
        input  pred_ready, flush, redirect_pc, upd_valid, upd_taken,
        input  err_underflow, err_overflow
    );

    modport slave (
        input  pred_valid, pred_taken, pred_pc, pred_target,
        input  res_valid, res_taken, res_target,
        output pred_ready, flush, redirect_pc, upd_valid, upd_taken,
        output err_underflow, err_overflow
    );

endinterface

// File: rtl/pred_track_fifo.sv
// rtl/pred_track_fifo.sv - in-order prediction tracking FIFO with wrap-bit pointers and flush-to-head+1
module pred_track_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head_data = mem[rd_ptr[AW-1:0]];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    // Pointer update; a flush rewinds wr_ptr to just past the entry being popped, emptying the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (flush) begin
                wr_ptr <= rd_ptr + (AW+1)'(1);
            end else if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
        end
    end

    // Entry storage; contents are only meaningful between the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/branch_outcome_checker.sv
// rtl/branch_outcome_checker.sv - execute-stage branch outcome checker; optional BOC_STATS_EN adds counters
module branch_outcome_checker
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    branch_outcome_checker_if.slave   bus
`ifdef BOC_STATS_EN
    ,
    output logic [CNT_W-1:0]          stat_branches,
    output logic [CNT_W-1:0]          stat_mispredicts,
    output logic [CNT_W-1:0]          stat_dir_miss
`endif
);

    localparam int ENT_W = 1 + 2 * PC_W;

    // Parameter sanity marker: an elaborated g_bad_params block means an unsupported configuration
    if (DEPTH < 2 || CNT_W < 1) begin : g_bad_params
    end

    boc_state_e      state;
    logic            pred_ready;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push_fire;
    logic            pop_fire;
    logic            dir_miss;
    logic            tgt_miss;
    logic            mispredict;
    logic [ENT_W-1:0] push_data;
    logic [ENT_W-1:0] head_data;
    logic            head_taken;
    logic [PC_W-1:0] head_pc;
    logic [PC_W-1:0] head_target;

    logic            flush_q;
    logic [PC_W-1:0] redirect_q;
    logic            upd_valid_q;
    logic            upd_taken_q;
    logic            err_underflow_q;
    logic            err_overflow_q;

    assign pred_ready  = !fifo_full && (state == TRACK);
    assign push_fire   = bus.pred_valid && pred_ready;
    assign pop_fire    = bus.res_valid && !fifo_empty;
    assign push_data   = {bus.pred_taken, bus.pred_pc, bus.pred_target};
    assign head_taken  = head_data[ENT_W-1];
    assign head_pc     = head_data[2*PC_W-1:PC_W];
    assign head_target = head_data[PC_W-1:0];
    assign dir_miss    = (head_taken != bus.res_taken);
    assign tgt_miss    = bus.res_taken && (head_target != bus.res_target);
    assign mispredict  = pop_fire && (dir_miss || tgt_miss);

    pred_track_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_fire),
        .push_data (push_data),
        .pop       (pop_fire),
        .flush     (mispredict),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Checker FSM plus registered flush/redirect, predictor update and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= TRACK;
            flush_q         <= 1'b0;
            redirect_q      <= '0;
            upd_valid_q     <= 1'b0;
            upd_taken_q     <= 1'b0;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
        end else begin
            case (state)
                TRACK:   state <= mispredict ? RECOVER : TRACK;
                RECOVER: state <= TRACK;
            endcase
            flush_q     <= mispredict;
            redirect_q  <= !mispredict ? '0 :
                           bus.res_taken ? bus.res_target : head_pc + PC_W'(PC_INC);
            upd_valid_q <= pop_fire;
            upd_taken_q <= pop_fire && bus.res_taken;
            if (bus.res_valid && fifo_empty) begin
                err_underflow_q <= 1'b1;
            end
            // Refusals during recovery, or on the mispredict cycle itself, are expected and not errors
            if (bus.pred_valid && !pred_ready && (state == TRACK) && !mispredict) begin
                err_overflow_q <= 1'b1;
            end
        end
    end

    assign bus.pred_ready    = pred_ready;
    assign bus.flush         = flush_q;
    assign bus.redirect_pc   = redirect_q;
    assign bus.upd_valid     = upd_valid_q;
    assign bus.upd_taken     = upd_taken_q;
    assign bus.err_underflow = err_underflow_q;
    assign bus.err_overflow  = err_overflow_q;

`ifdef BOC_STATS_EN
    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
            stat_dir_miss    <= '0;
        end else begin
            if (pop_fire && (stat_branches != '1)) begin
                stat_branches <= stat_branches + CNT_W'(1);
            end
            if (mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + CNT_W'(1);
            end
            if (mispredict && dir_miss && (stat_dir_miss != '1)) begin
                stat_dir_miss <= stat_dir_miss + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_outcome_checker.sv
// tb/tb_branch_outcome_checker.sv - self-checking bench for branch_outcome_checker
module tb_branch_outcome_checker;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    branch_outcome_checker_if #(.PC_W(PC_W)) bif ();

`ifdef BOC_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;
    logic [15:0] stat_dir_miss;
`endif

    branch_outcome_checker #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W),
        .CNT_W (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
`ifdef BOC_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
        .stat_dir_miss    (stat_dir_miss)
`endif
    );

    typedef struct {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } ent_t;

    ent_t        mq[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic        m_recover;
    logic        m_uf;
    logic        m_of;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bif.pred_valid  = 1'b0;
        bif.pred_taken  = 1'b0;
        bif.pred_pc     = '0;
        bif.pred_target = '0;
        bif.res_valid   = 1'b0;
        bif.res_taken   = 1'b0;
        bif.res_target  = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_recover = 1'b0;
        m_uf      = 1'b0;
        m_of      = 1'b0;
    endtask

    // One clock of stimulus: inputs applied at negedge, results checked 1 time unit after posedge
    task automatic step(input logic pv, input logic pt, input logic [31:0] ppc, input logic [31:0] ptgt,
                        input logic rv, input logic rt, input logic [31:0] rtgt);
        logic        ready;
        logic        misp;
        logic        e_upd;
        logic        e_upd_taken;
        logic        e_flush;
        logic [31:0] e_redir;
        ent_t        h;
        @(negedge clk);
        ready = (mq.size() < DEPTH) && !m_recover;
        check("pred_ready", {31'b0, bif.pred_ready}, {31'b0, ready});
        bif.pred_valid  = pv;
        bif.pred_taken  = pt;
        bif.pred_pc     = ppc;
        bif.pred_target = ptgt;
        bif.res_valid   = rv;
        bif.res_taken   = rt;
        bif.res_target  = rtgt;
        misp = 1'b0; e_upd = 1'b0; e_upd_taken = 1'b0; e_flush = 1'b0; e_redir = '0;
        if (rv) begin
            if (mq.size() == 0) begin
                m_uf = 1'b1;
            end else begin
                h           = mq.pop_front();
                e_upd       = 1'b1;
                e_upd_taken = rt;
                misp        = (h.taken != rt) || (rt && (h.target != rtgt));
                e_flush     = misp;
                e_redir     = rt ? rtgt : h.pc + 32'd4;
            end
        end
        if (pv && !misp) begin
            if (ready) mq.push_back('{pt, ppc, ptgt});
            else if (!m_recover) m_of = 1'b1;
        end
        if (misp) mq.delete();
        m_recover = misp;
        @(posedge clk);
        #1;
        idle_inputs();
        check("upd_valid", {31'b0, bif.upd_valid}, {31'b0, e_upd});
        if (e_upd) check("upd_taken", {31'b0, bif.upd_taken}, {31'b0, e_upd_taken});
        check("flush", {31'b0, bif.flush}, {31'b0, e_flush});
        if (e_flush) check("redirect_pc", bif.redirect_pc, e_redir);
        check("err_underflow", {31'b0, bif.err_underflow}, {31'b0, m_uf});
        check("err_overflow", {31'b0, bif.err_overflow}, {31'b0, m_of});
    endtask

    task automatic push(input logic pt, input logic [31:0] ppc, input logic [31:0] ptgt);
        step(1'b1, pt, ppc, ptgt, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic rt, input logic [31:0] rtgt);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, rt, rtgt);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve_head_ok();
        resolve(mq[0].taken, mq[0].target);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear before any edge
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pred_ready", {31'b0, bif.pred_ready}, 32'd1);
        check("rst_flush", {31'b0, bif.flush}, 32'd0);
        check("rst_upd_valid", {31'b0, bif.upd_valid}, 32'd0);
        check("rst_err_underflow", {31'b0, bif.err_underflow}, 32'd0);
        check("rst_err_overflow", {31'b0, bif.err_overflow}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        do_reset();

        // Correct taken prediction
        push(1'b1, 32'h100, 32'h200);
        resolve(1'b1, 32'h200);

        // Direction miss: predicted not-taken, actually taken
        push(1'b0, 32'h40, 32'h0);
        resolve(1'b1, 32'h80);
        idle_step();

        // Direction miss: predicted taken, actually not-taken
        push(1'b1, 32'h40, 32'h80);
        resolve(1'b0, 32'h0);
        idle_step();

        // Fall-through redirect wraps at the top of the address space
        push(1'b1, 32'hFFFF_FFFC, 32'h1000);
        resolve(1'b0, 32'h0);
        idle_step();

        // Target miss with younger entries queued, then push during recovery
        push(1'b1, 32'h10, 32'h280);
        push(1'b0, 32'h14, 32'h0);
        push(1'b1, 32'h18, 32'h500);
        resolve(1'b1, 32'h300);
        push(1'b1, 32'h20, 32'h600);
        resolve(1'b0, 32'h0);

        // Full, overflow, and pointer wrap with alternating pop/push
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(i[0], 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 16));
        push(1'b1, 32'h1100, 32'h2100);
        step(1'b1, 1'b0, 32'h1200, 32'h0, 1'b1, mq[0].taken, mq[0].target);
        for (int i = 0; i < 10; i++) begin
            resolve_head_ok();
            push(i[1], 32'h3000 + 32'(i * 4), 32'h4000 + 32'(i * 8));
        end
        while (mq.size() > 0) resolve_head_ok();

        // Underflow on an empty queue
        do_reset();
        resolve(1'b1, 32'h0);
        idle_step();

        // Randomized traffic against the queue model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic        pv, pt, rv, rt;
            logic [31:0] ppc, ptgt, rtgt;
            pv   = ($urandom_range(0, 9) < 6);
            pt   = $urandom_range(0, 1);
            ppc  = $urandom() & 32'hFFFF_FFFC;
            ptgt = 32'h200 + 32'($urandom_range(0, 1) * 4);
            rv   = ($urandom_range(0, 9) < 4);
            rt   = $urandom_range(0, 1);
            rtgt = 32'h200 + 32'($urandom_range(0, 1) * 4);
            if (rv && mq.size() > 0 && $urandom_range(0, 1) == 1) begin
                rt   = mq[0].taken;
                rtgt = mq[0].target;
            end
            step(pv, pt, ppc, ptgt, rv, rt, rtgt);
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        // Reset mid-flight: two entries queued and an update pulse pending
        while (mq.size() > 0 && !m_recover) resolve_head_ok();
        idle_step();
        push(1'b1, 32'h500, 32'h600);
        push(1'b0, 32'h504, 32'h0);
        push(1'b1, 32'h508, 32'h700);
        resolve(1'b1, 32'h600);
        do_reset();
        resolve(1'b1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
